// File: rtl/acf_frame_controller.sv
// Frames the incoming sample stream into fixed-size ACF blocks and collects the
// per-block ACF lag sums into a readable bank with full/release handshaking.
module acf_frame_controller #(
    parameter int unsigned BLOCK_SIZE = 4096,
    parameter int unsigned ORDER      = 12,
    parameter int unsigned ACF_WIDTH  = 43
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iEnable,
    input  logic [15:0]          iSample,
    input  logic                 iValid,
    output logic [15:0]          oSample,
    output logic                 oValid,
    output logic                 oBlockStart,
    output logic                 oBlockEnd,
    input  logic [ACF_WIDTH-1:0] iACF,
    input  logic                 iACFValid,
    input  logic [3:0]           iLagSel,
    output logic [ACF_WIDTH-1:0] oACF,
    output logic                 oBankFull,
    input  logic                 iBankRelease,
    output logic                 oOverflow,
    output logic [15:0]          oBlockCount
);

    localparam int unsigned CNT_W      = $clog2(BLOCK_SIZE);
    localparam int unsigned LAG_W      = 4;
    localparam int unsigned BANK_DEPTH = 16;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [LAG_W-1:0] LAST_LAG    = LAG_W'(ORDER - 1);
    localparam logic [LAG_W:0]   ORDER_L     = (LAG_W + 1)'(ORDER);

    typedef enum logic {
        SF_IDLE,
        SF_RUN
    } sf_state_t;

    sf_state_t              state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [15:0]            sample_nxt;
    logic                   valid_nxt;
    logic                   start_nxt;
    logic                   end_nxt;
    logic [15:0]            block_cnt_nxt;

    logic [ACF_WIDTH-1:0]   bank [BANK_DEPTH];
    logic [LAG_W-1:0]       lag_idx_q, lag_idx_nxt;
    logic [LAG_W-1:0]       write_idx;
    logic                   bank_we;
    logic                   release_ok;
    logic                   full_nxt;
    logic                   overflow_nxt;
    logic [ACF_WIDTH-1:0]   acf_nxt;

    // Sample framing: next-state and registered-output values
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        sample_nxt    = oSample;
        valid_nxt     = 1'b0;
        start_nxt     = 1'b0;
        end_nxt       = 1'b0;
        block_cnt_nxt = oBlockCount;
        case (state_q)
            SF_IDLE: begin
                if (iValid && iEnable) begin
                    sample_nxt = iSample;
                    valid_nxt  = 1'b1;
                    start_nxt  = 1'b1;
                    cnt_nxt    = CNT_W'(1);
                    state_nxt  = SF_RUN;
                end
            end
            SF_RUN: begin
                if (iValid) begin
                    sample_nxt = iSample;
                    valid_nxt  = 1'b1;
                    if (cnt_q == LAST_SAMPLE) begin
                        end_nxt       = 1'b1;
                        block_cnt_nxt = oBlockCount + 16'd1;
                        cnt_nxt       = '0;
                        state_nxt     = SF_IDLE;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = SF_IDLE;
        endcase
    end

    // Lag collector: a release frees the bank in the same cycle a new value lands
    always_comb begin
        release_ok   = iBankRelease && oBankFull;
        bank_we      = iACFValid && (!oBankFull || release_ok);
        write_idx    = release_ok ? '0 : lag_idx_q;
        lag_idx_nxt  = lag_idx_q;
        full_nxt     = oBankFull;
        overflow_nxt = oOverflow;
        if (release_ok) begin
            full_nxt = 1'b0;
        end
        if (bank_we) begin
            if (write_idx == LAST_LAG) begin
                lag_idx_nxt = '0;
                full_nxt    = 1'b1;
            end else begin
                lag_idx_nxt = write_idx + LAG_W'(1);
            end
        end
        if (iACFValid && oBankFull && !iBankRelease) begin
            overflow_nxt = 1'b1;
        end
        acf_nxt = ({1'b0, iLagSel} < ORDER_L) ? bank[iLagSel] : '0;
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q     <= SF_IDLE;
            cnt_q       <= '0;
            oSample     <= '0;
            oValid      <= 1'b0;
            oBlockStart <= 1'b0;
            oBlockEnd   <= 1'b0;
            oBlockCount <= '0;
            lag_idx_q   <= '0;
            oBankFull   <= 1'b0;
            oOverflow   <= 1'b0;
            oACF        <= '0;
            for (int i = 0; i < BANK_DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            oSample     <= sample_nxt;
            oValid      <= valid_nxt;
            oBlockStart <= start_nxt;
            oBlockEnd   <= end_nxt;
            oBlockCount <= block_cnt_nxt;
            lag_idx_q   <= lag_idx_nxt;
            oBankFull   <= full_nxt;
            oOverflow   <= overflow_nxt;
            oACF        <= acf_nxt;
            if (bank_we) begin
                bank[write_idx] <= iACF;
            end
        end
    end

endmodule

// File: tb/tb_acf_frame_controller.sv
// Directed and randomized checks of acf_frame_controller against a block/bank
// reference model; a second default-sized instance covers mid-block reset.
module tb_acf_frame_controller;

    localparam int BS  = 8;
    localparam int ORD = 4;
    localparam int AW  = 43;

    logic          iClock = 1'b0;
    logic          iReset, iEnable, iValid, iACFValid, iBankRelease;
    logic [15:0]   iSample;
    logic [AW-1:0] iACF;
    logic [3:0]    iLagSel;
    logic [15:0]   oSample, oBlockCount;
    logic          oValid, oBlockStart, oBlockEnd, oBankFull, oOverflow;
    logic [AW-1:0] oACF;

    logic          r2, en2, v2;
    logic [15:0]   s2, samp2, cnt2;
    logic          val2, start2, end2, full2, ovf2;
    logic [AW-1:0] acf2;

    int n_vec = 0;
    int n_err = 0;

    always #5 iClock = ~iClock;

    acf_frame_controller #(.BLOCK_SIZE(BS), .ORDER(ORD), .ACF_WIDTH(AW)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iSample(iSample),
        .iValid(iValid), .oSample(oSample), .oValid(oValid), .oBlockStart(oBlockStart),
        .oBlockEnd(oBlockEnd), .iACF(iACF), .iACFValid(iACFValid), .iLagSel(iLagSel),
        .oACF(oACF), .oBankFull(oBankFull), .iBankRelease(iBankRelease),
        .oOverflow(oOverflow), .oBlockCount(oBlockCount)
    );

    acf_frame_controller dut_big (
        .iClock(iClock), .iReset(r2), .iEnable(en2), .iSample(s2), .iValid(v2),
        .oSample(samp2), .oValid(val2), .oBlockStart(start2), .oBlockEnd(end2),
        .iACF('0), .iACFValid(1'b0), .iLagSel(4'd0), .oACF(acf2), .oBankFull(full2),
        .iBankRelease(1'b0), .oOverflow(ovf2), .oBlockCount(cnt2)
    );

    // Reference model: samples taken into the current block, and the lag bank contents
    int          m_pos;
    int          m_blocks;
    int          m_fill;
    bit          m_full;
    bit          m_ovf;
    logic [63:0] m_bank [16];

    task automatic model_reset();
        m_pos = 0; m_blocks = 0; m_fill = 0; m_full = 0; m_ovf = 0;
        for (int i = 0; i < 16; i++) m_bank[i] = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic en, input logic [15:0] s,
                        input logic av, input logic [AW-1:0] a, input logic [3:0] lag,
                        input logic rel);
        logic        e_valid, e_start, e_end;
        logic [15:0] e_samp;
        logic [63:0] e_acf;
        bit          rel_ok;
        iReset = rst; iValid = v; iEnable = en; iSample = s;
        iACFValid = av; iACF = a; iLagSel = lag; iBankRelease = rel;
        e_valid = 0; e_start = 0; e_end = 0; e_samp = '0; e_acf = '0;
        if (!rst) begin
            model_reset();
        end else begin
            if (v && (m_pos != 0 || en)) begin
                e_valid = 1; e_samp = s; e_start = (m_pos == 0);
                m_pos++;
                if (m_pos == BS) begin
                    e_end = 1; m_pos = 0; m_blocks = (m_blocks + 1) % 65536;
                end
            end
            e_acf = (int'(lag) < ORD) ? m_bank[lag] : 64'd0;
            rel_ok = rel && m_full;
            if (rel_ok) begin
                m_full = 0; m_fill = 0;
            end
            if (av) begin
                if (m_full) begin
                    m_ovf = 1;
                end else begin
                    m_bank[m_fill] = 64'(a);
                    m_fill++;
                    if (m_fill == ORD) begin
                        m_full = 1; m_fill = 0;
                    end
                end
            end
        end
        @(posedge iClock);
        @(negedge iClock);
        chk("oValid", 64'(oValid), 64'(e_valid));
        if (e_valid || !rst) chk("oSample", 64'(oSample), 64'(e_samp));
        chk("oBlockStart", 64'(oBlockStart), 64'(e_start));
        chk("oBlockEnd", 64'(oBlockEnd), 64'(e_end));
        chk("oBlockCount", 64'(oBlockCount), 64'(m_blocks));
        chk("oBankFull", 64'(oBankFull), 64'(m_full));
        chk("oOverflow", 64'(oOverflow), 64'(m_ovf));
        chk("oACF", 64'(oACF), e_acf);
    endtask

    task automatic idle(input logic [3:0] lag);
        step(1, 0, 0, 16'd0, 0, '0, lag, 0);
    endtask

    task automatic big_cycle(input logic rst, input logic [15:0] s);
        r2 = rst; en2 = 1'b1; v2 = 1'b1; s2 = s;
        @(posedge iClock);
        @(negedge iClock);
    endtask

    initial begin
        int ends, end_at;
        r2 = 0; en2 = 0; v2 = 0; s2 = '0;
        model_reset();
        @(negedge iClock);
        step(0, 0, 0, 16'd0, 0, '0, 4'd0, 0);
        step(0, 1, 1, 16'h1234, 1, 43'd7, 4'd0, 1);

        // One contiguous block of 1..8
        for (int i = 1; i <= 8; i++) step(1, 1, 1, 16'(i), 0, '0, 4'd0, 0);
        idle(4'd0);

        // Disabled samples are dropped, block starts with 7
        step(1, 1, 0, 16'd5, 0, '0, 4'd0, 0);
        step(1, 1, 0, 16'd6, 0, '0, 4'd0, 0);
        for (int i = 7; i <= 14; i++) step(1, 1, 1, 16'(i), 0, '0, 4'd0, 0);

        // 16 samples with a gap every other cycle, enable dropped mid-block
        for (int i = 0; i < 16; i++) begin
            step(1, 1, (i % 8) == 0, 16'(16'h8000 + i), 0, '0, 4'd0, 0);
            idle(4'd0);
        end

        // Bank fill, read, overflow
        step(1, 0, 0, 16'd0, 1, 43'd10, 4'd0, 0);
        step(1, 0, 0, 16'd0, 1, 43'd20, 4'd0, 0);
        step(1, 0, 0, 16'd0, 1, 43'd30, 4'd0, 0);
        step(1, 0, 0, 16'd0, 1, 43'd40, 4'd2, 0);
        idle(4'd2);
        step(1, 0, 0, 16'd0, 1, 43'd50, 4'd0, 0);
        idle(4'd0);
        idle(4'd9);
        step(1, 0, 0, 16'd0, 0, '0, 4'd0, 1);
        step(1, 0, 0, 16'd0, 0, '0, 4'd0, 1);

        // Release wins over a simultaneous write while full
        step(0, 0, 0, 16'd0, 0, '0, 4'd0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'd0, 1, 43'(i * 11), 4'(i - 1), 0);
        step(1, 0, 0, 16'd0, 1, 43'd99, 4'd0, 1);
        idle(4'd0);
        idle(4'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0, 16'($urandom()), $urandom_range(0, 1) == 1,
                 43'({$urandom(), $urandom()}), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 5) == 0);
        end

        // Reset mid-block aborts it; next block restarts from sample 0
        step(0, 0, 0, 16'd0, 0, '0, 4'd0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 16'(i), 0, '0, 4'd0, 0);
        step(0, 1, 1, 16'd77, 0, '0, 4'd0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 1, 16'(100 + i), 0, '0, 4'd0, 0);

        // Default-sized instance: reset at sample 2000, then exactly one full block
        big_cycle(0, 16'd0);
        for (int i = 0; i < 2000; i++) big_cycle(1, 16'(i));
        big_cycle(0, 16'hffff);
        chk("big_count_after_reset", 64'(cnt2), 64'd0);
        chk("big_valid_in_reset", 64'(val2), 64'd0);
        ends = 0; end_at = -1;
        for (int i = 1; i <= 4096; i++) begin
            big_cycle(1, 16'(i));
            if (i == 1) chk("big_first_start", 64'(start2), 64'd1);
            if (end2) begin
                ends++;
                end_at = i;
            end
        end
        chk("big_end_pulses", 64'(ends), 64'd1);
        chk("big_end_position", 64'(end_at), 64'd4096);
        chk("big_block_count", 64'(cnt2), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
